// File: rtl/sr_to_t_drv_if.sv
// Handshake and excitation bundle between a T-command source and sr_to_t_drv.
// Carries toggle commands, SR excitation, Q feedback and status/error signals.
// Master drives commands, feedback and err_clr; slave (the driver) drives the rest.
interface sr_to_t_drv_if #(
   parameter int WIDTH = 4
);
   logic             t_valid;
   logic [WIDTH-1:0] t_in;
   logic             t_ready;
   logic [WIDTH-1:0] q_fb;
   logic [WIDTH-1:0] s_out;
   logic [WIDTH-1:0] r_out;
   logic [WIDTH-1:0] q_model;
   logic             done;
   logic             err;
   logic [WIDTH-1:0] err_mask;
   logic             err_clr;

   modport master (
      output t_valid, t_in, q_fb, err_clr,
      input  t_ready, s_out, r_out, q_model, done, err, err_mask
   );

   modport slave (
      input  t_valid, t_in, q_fb, err_clr,
      output t_ready, s_out, r_out, q_model, done, err, err_mask
   );
endinterface

// File: rtl/sr_to_t_drv.sv
// Purpose: emulates WIDTH toggle flip-flops by pulsing S/R on external SR flops and verifying Q.
// Latency: PULSE_CYCLES + SETTLE_CYCLES + 1 cycles accept-to-done (4 at defaults); zero command done next cycle.
// Backpressure: t_ready only in IDLE; held low while driving, checking or in ERROR until err_clr.
// Optional: SR_TO_T_TOGCNT_EN adds a saturating 16-bit tog_cnt of toggled channels per successful command.
module sr_to_t_drv #(
   parameter int WIDTH         = 4,
   parameter int PULSE_CYCLES  = 1,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   sr_to_t_drv_if.slave   bus
`ifdef SR_TO_T_TOGCNT_EN
   ,
   output logic [15:0]    tog_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, DRIVE, CHECK, ERROR} state_t;

   state_t           state, state_nxt;
   logic [3:0]       cnt, cnt_nxt;
   logic [WIDTH-1:0] t_cap, t_cap_nxt;
   logic [WIDTH-1:0] s_nxt, r_nxt;
   logic [WIDTH-1:0] q_model_nxt;
   logic [WIDTH-1:0] err_mask_nxt;
   logic             done_nxt, err_nxt, t_ready_nxt;
   logic [WIDTH-1:0] q_exp;

   // Flop state each channel should reach once the captured toggles land.
   assign q_exp = bus.q_model ^ t_cap;

   // Register the FSM and every output; reset drops excitation without waiting for a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         t_cap        <= '0;
         bus.s_out    <= '0;
         bus.r_out    <= '0;
         bus.q_model  <= '0;
         bus.done     <= 1'b0;
         bus.err      <= 1'b0;
         bus.err_mask <= '0;
         bus.t_ready  <= 1'b1;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         t_cap        <= t_cap_nxt;
         bus.s_out    <= s_nxt;
         bus.r_out    <= r_nxt;
         bus.q_model  <= q_model_nxt;
         bus.done     <= done_nxt;
         bus.err      <= err_nxt;
         bus.err_mask <= err_mask_nxt;
         bus.t_ready  <= t_ready_nxt;
      end
   end

   // Next-state and next-output decode; S and R derive from disjoint halves of q_model so never overlap.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      t_cap_nxt    = t_cap;
      s_nxt        = '0;
      r_nxt        = '0;
      q_model_nxt  = bus.q_model;
      done_nxt     = 1'b0;
      err_nxt      = bus.err;
      err_mask_nxt = bus.err_mask;
      case (state)
         IDLE: begin
            if (bus.t_valid && bus.t_ready) begin
               if (bus.t_in != '0) begin
                  t_cap_nxt = bus.t_in;
                  s_nxt     = bus.t_in & ~bus.q_model;
                  r_nxt     = bus.t_in & bus.q_model;
                  cnt_nxt   = 4'(PULSE_CYCLES - 1);
                  state_nxt = DRIVE;
               end else begin
                  done_nxt = 1'b1;
               end
            end
         end
         DRIVE: begin
            if (cnt == '0) begin
               cnt_nxt   = 4'(SETTLE_CYCLES - 1);
               state_nxt = CHECK;
            end else begin
               cnt_nxt = cnt - 4'd1;
               s_nxt   = bus.s_out;
               r_nxt   = bus.r_out;
            end
         end
         CHECK: begin
            if (cnt == '0) begin
               if (bus.q_fb == q_exp) begin
                  q_model_nxt = q_exp;
                  done_nxt    = 1'b1;
                  state_nxt   = IDLE;
               end else begin
                  err_nxt      = 1'b1;
                  err_mask_nxt = q_exp ^ bus.q_fb;
                  state_nxt    = ERROR;
               end
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         ERROR: begin
            if (bus.err_clr) begin
               q_model_nxt  = bus.q_fb;
               err_nxt      = 1'b0;
               err_mask_nxt = '0;
               state_nxt    = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      t_ready_nxt = (state_nxt == IDLE);
   end

`ifdef SR_TO_T_TOGCNT_EN
   logic [15:0] pop;
   logic [16:0] tog_sum;
   logic        tog_hit;

   // Count toggled channels of the captured command and form the saturating sum.
   always_comb begin
      pop = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pop = pop + 16'(t_cap[i]);
      end
      tog_sum = {1'b0, tog_cnt} + {1'b0, pop};
      tog_hit = (state == CHECK) && (cnt == '0) && (bus.q_fb == q_exp);
   end

   // Accumulate only on commands that verified successfully.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tog_cnt <= '0;
      end else if (tog_hit) begin
         tog_cnt <= tog_sum[16] ? 16'hFFFF : tog_sum[15:0];
      end
   end
`endif

endmodule
